// File: rtl/cp_inserter.sv
// OFDM cyclic-prefix inserter: buffers one Nfft-sample symbol, then emits its last Ng
// samples followed by the whole symbol, repeated n_sym times per go.
module cp_inserter #(
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_NFFT = 2048,
    parameter int unsigned AW       = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [11:0]          Ng,
    input  logic [11:0]          Nfft,
    input  logic [11:0]          n_sym,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_i,
    input  logic signed [DW-1:0] in_q,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_i,
    output logic signed [DW-1:0] out_q,
    input  logic                 out_ready,
    output logic                 sym_start,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam logic [11:0] MaxNfft = 12'(MAX_NFFT);

    typedef enum logic [2:0] {StIdle, StLoad, StCp, StBody, StFin} state_e;

    state_e state_q, state_d;
    logic [11:0] ng_q, ng_d, nfft_q, nfft_d, nsym_q, nsym_d;
    logic [11:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, sym_q, sym_d;
    logic        out_valid_q, out_valid_d, sym_start_q, sym_start_d;
    logic        done_q, done_d, cfg_err_q, cfg_err_d;
    logic signed [DW-1:0] out_i_q, out_i_d, out_q_q, out_q_d;

    logic [2*DW-1:0] mem [MAX_NFFT];
    logic [2*DW-1:0] rdata;
    logic [11:0]     raddr_full;
    logic [AW-1:0]   raddr, waddr;
    logic            wr_en, rd_en, out_load, cfg_bad;
    logic            unused_addr_msb;

    assign out_load   = !out_valid_q || out_ready;
    assign cfg_bad    = (Nfft == 12'd0) || (Nfft > MaxNfft) || (Ng > Nfft);
    assign raddr_full = (state_q == StCp) ? (nfft_q - ng_q + rcnt_q) : rcnt_q;
    assign raddr      = raddr_full[AW-1:0];
    assign waddr      = wcnt_q[AW-1:0];
    assign rdata      = mem[raddr];
    // Addresses never reach Nfft, so the counter MSBs above AW carry no address information.
    assign unused_addr_msb = ^{raddr_full[11:AW], wcnt_q[11:AW]};

    always_comb begin
        state_d     = state_q;
        ng_d        = ng_q;
        nfft_d      = nfft_q;
        nsym_d      = nsym_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        sym_d       = sym_q;
        out_valid_d = out_valid_q;
        sym_start_d = sym_start_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        // Output slot frees up; refilled below if a read is issued this cycle.
        if (out_load) begin
            out_valid_d = 1'b0;
            sym_start_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        ng_d    = Ng;
                        nfft_d  = Nfft;
                        nsym_d  = (n_sym == 12'd0) ? 12'd1 : n_sym;
                        wcnt_d  = '0;
                        rcnt_d  = '0;
                        sym_d   = '0;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wcnt_q == nfft_q - 12'd1) begin
                        wcnt_d  = '0;
                        rcnt_d  = '0;
                        state_d = (ng_q != 12'd0) ? StCp : StBody;
                    end else begin
                        wcnt_d = wcnt_q + 12'd1;
                    end
                end
            end
            StCp: begin
                if (out_load) begin
                    rd_en       = 1'b1;
                    sym_start_d = (rcnt_q == 12'd0);
                    if (rcnt_q == ng_q - 12'd1) begin
                        rcnt_d  = '0;
                        state_d = StBody;
                    end else begin
                        rcnt_d = rcnt_q + 12'd1;
                    end
                end
            end
            StBody: begin
                if (out_load) begin
                    rd_en       = 1'b1;
                    sym_start_d = (rcnt_q == 12'd0) && (ng_q == 12'd0);
                    if (rcnt_q == nfft_q - 12'd1) begin
                        rcnt_d = '0;
                        if (sym_q + 12'd1 < nsym_q) begin
                            sym_d   = sym_q + 12'd1;
                            state_d = StLoad;
                        end else begin
                            state_d = StFin;
                        end
                    end else begin
                        rcnt_d = rcnt_q + 12'd1;
                    end
                end
            end
            StFin: begin
                // Hold off done until the final sample has left the output register.
                if (out_load) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (rd_en) begin
            out_valid_d = 1'b1;
            out_i_d     = rdata[2*DW-1:DW];
            out_q_d     = rdata[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ng_q        <= '0;
            nfft_q      <= '0;
            nsym_q      <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            sym_q       <= '0;
            out_valid_q <= 1'b0;
            sym_start_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ng_q        <= ng_d;
            nfft_q      <= nfft_d;
            nsym_q      <= nsym_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            sym_q       <= sym_d;
            out_valid_q <= out_valid_d;
            sym_start_q <= sym_start_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= {in_i, in_q};
        end
    end

    assign in_ready  = (state_q == StLoad);
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign sym_start = sym_start_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule
